// File: rtl/if_id_stage_buffer.sv
// IF/ID pipeline register: latches fetched words with PC+1 and merges opcode+immediate
// pairs into one decoded packet, with hazard stall and branch flush.
module if_id_stage_buffer #(
   parameter int                DATA_W   = 16,
   parameter int                PC_W     = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instr,
   input  logic [PC_W-1:0]   pc_plus1,
   input  logic              has_imm,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] o_instr,
   output logic [DATA_W-1:0] o_imm,
   output logic [PC_W-1:0]   o_pc_plus1,
   output logic              o_valid,
   output logic              o_bubble,
   output logic              o_wait_imm
);

   typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

   state_t            state_r, state_n;
   logic [DATA_W-1:0] hold_r, hold_n;
   logic [DATA_W-1:0] instr_n, imm_n;
   logic [PC_W-1:0]   pc_n;
   logic              valid_n;

   // Register update; every output is a flop so no input reaches an output combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_OP;
         hold_r     <= '0;
         o_instr    <= NOP_WORD;
         o_imm      <= '0;
         o_pc_plus1 <= '0;
         o_valid    <= 1'b0;
      end else begin
         state_r    <= state_n;
         hold_r     <= hold_n;
         o_instr    <= instr_n;
         o_imm      <= imm_n;
         o_pc_plus1 <= pc_n;
         o_valid    <= valid_n;
      end
   end

   // Next-state logic: flush beats stall, stall freezes everything.
   always_comb begin
      state_n = state_r;
      hold_n  = hold_r;
      instr_n = o_instr;
      imm_n   = o_imm;
      pc_n    = o_pc_plus1;
      valid_n = o_valid;
      if (flush) begin
         state_n = S_OP;
         hold_n  = '0;
         instr_n = NOP_WORD;
         imm_n   = '0;
         valid_n = 1'b0;
      end else if (stall) begin
         state_n = state_r;
      end else begin
         case (state_r)
            S_OP: begin
               if (has_imm) begin
                  hold_n  = instr;
                  instr_n = NOP_WORD;
                  imm_n   = '0;
                  valid_n = 1'b0;
                  state_n = S_IMM;
               end else begin
                  instr_n = instr;
                  imm_n   = '0;
                  pc_n    = pc_plus1;
                  valid_n = 1'b1;
                  state_n = S_OP;
               end
            end
            // The incoming word is the immediate; has_imm is meaningless for data.
            S_IMM: begin
               instr_n = hold_r;
               imm_n   = instr;
               pc_n    = pc_plus1;
               valid_n = 1'b1;
               state_n = S_OP;
            end
            default: begin
               state_n = S_OP;
               instr_n = NOP_WORD;
               imm_n   = '0;
               valid_n = 1'b0;
            end
         endcase
      end
   end

   assign o_bubble   = ~o_valid;
   assign o_wait_imm = (state_r == S_IMM);

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Scoreboard bench for if_id_stage_buffer: stimulus pushes expected packets,
// a negedge monitor pops and compares each newly presented valid packet.
module tb_if_id_stage_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic [31:0] pc_plus1;
   logic        has_imm, stall, flush;
   logic [15:0] o_instr, o_imm;
   logic [31:0] o_pc_plus1;
   logic        o_valid, o_bubble, o_wait_imm;

   typedef struct {
      logic [15:0] ins;
      logic [15:0] imm;
      logic [31:0] pc;
   } pkt_t;

   pkt_t q[$];
   int   checks   = 0;
   int   failures = 0;
   logic adv      = 1'b0;

   if_id_stage_buffer dut (
      .clk(clk), .rst(rst), .instr(instr), .pc_plus1(pc_plus1), .has_imm(has_imm),
      .stall(stall), .flush(flush), .o_instr(o_instr), .o_imm(o_imm),
      .o_pc_plus1(o_pc_plus1), .o_valid(o_valid), .o_bubble(o_bubble),
      .o_wait_imm(o_wait_imm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // An edge advances the pipe only when not held by reset or an unflushed stall.
   always @(posedge clk) adv = !rst && (!stall || flush);

   always @(negedge clk) begin
      if (adv && o_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_packet actual=%h/%h/%h expected=none", o_instr, o_imm, o_pc_plus1);
         end else begin
            pkt_t e;
            e = q.pop_front();
            chk("pkt_instr", {16'h0000, o_instr}, {16'h0000, e.ins});
            chk("pkt_imm", {16'h0000, o_imm}, {16'h0000, e.imm});
            chk("pkt_pc", o_pc_plus1, e.pc);
         end
      end
   end

   task automatic step(input logic [15:0] i, input logic [31:0] p, input logic h,
                       input logic s, input logic f);
      instr = i; pc_plus1 = p; has_imm = h; stall = s; flush = f;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_pkt(input logic [15:0] i, input logic [15:0] m, input logic [31:0] p);
      pkt_t e;
      e.ins = i; e.imm = m; e.pc = p;
      q.push_back(e);
   endtask

   task automatic chk_flags(input string name, input logic v, input logic w);
      chk({name, "_valid"}, {31'd0, o_valid}, {31'd0, v});
      chk({name, "_bubble"}, {31'd0, o_bubble}, {31'd0, ~v});
      chk({name, "_wait"}, {31'd0, o_wait_imm}, {31'd0, w});
   endtask

   initial begin
      rst = 1'b1; instr = 16'h0000; pc_plus1 = 32'd0; has_imm = 1'b0; stall = 1'b0; flush = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rst_instr", {16'h0000, o_instr}, 32'h0000_0000);
      chk("rst_imm", {16'h0000, o_imm}, 32'h0000_0000);
      chk("rst_pc", o_pc_plus1, 32'd0);
      chk_flags("rst", 1'b0, 1'b0);

      // single-word opcode
      expect_pkt(16'h1234, 16'h0000, 32'd5);
      step(16'h1234, 32'd5, 1'b0, 1'b0, 1'b0);
      chk_flags("single", 1'b1, 1'b0);

      // two-word instruction with one bubble
      step(16'hA100, 32'd8, 1'b1, 1'b0, 1'b0);
      chk_flags("two_first", 1'b0, 1'b1);
      chk("two_first_nop", {16'h0000, o_instr}, 32'h0000_0000);
      expect_pkt(16'hA100, 16'h00FF, 32'd9);
      step(16'h00FF, 32'd9, 1'b0, 1'b0, 1'b0);
      chk_flags("two_second", 1'b1, 1'b0);

      // stall three cycles in S_IMM; has_imm=1 on the data word must be ignored
      step(16'hB200, 32'd20, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(16'h00AA, 32'd21, 1'b1, 1'b1, 1'b0);
         chk_flags("stall", 1'b0, 1'b1);
         chk("stall_instr", {16'h0000, o_instr}, 32'h0000_0000);
         chk("stall_pc", o_pc_plus1, 32'd9);
      end
      expect_pkt(16'hB200, 16'h00AA, 32'd21);
      step(16'h00AA, 32'd21, 1'b1, 1'b0, 1'b0);
      chk_flags("stall_release", 1'b1, 1'b0);

      // asynchronous reset between edges while in S_IMM
      step(16'hC300, 32'd30, 1'b1, 1'b0, 1'b0);
      chk_flags("pre_rst", 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_instr", {16'h0000, o_instr}, 32'h0000_0000);
      chk("arst_imm", {16'h0000, o_imm}, 32'h0000_0000);
      chk("arst_pc", o_pc_plus1, 32'd0);
      chk_flags("arst", 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      expect_pkt(16'h3333, 16'h0000, 32'd31);
      step(16'h3333, 32'd31, 1'b0, 1'b0, 1'b0);
      chk_flags("post_rst", 1'b1, 1'b0);

      // flush overrides stall in S_IMM
      step(16'hD400, 32'd40, 1'b1, 1'b0, 1'b0);
      chk_flags("pre_flush", 1'b0, 1'b1);
      step(16'h0055, 32'd41, 1'b0, 1'b1, 1'b1);
      chk_flags("flush", 1'b0, 1'b0);
      chk("flush_instr", {16'h0000, o_instr}, 32'h0000_0000);
      chk("flush_imm", {16'h0000, o_imm}, 32'h0000_0000);
      expect_pkt(16'h2222, 16'h0000, 32'd42);
      step(16'h2222, 32'd42, 1'b0, 1'b0, 1'b0);
      chk_flags("post_flush", 1'b1, 1'b0);

      // back-to-back two-word instructions: valid 0,1,0,1
      step(16'hE500, 32'd50, 1'b1, 1'b0, 1'b0);
      chk_flags("b2b0", 1'b0, 1'b1);
      expect_pkt(16'hE500, 16'h0001, 32'd51);
      step(16'h0001, 32'd51, 1'b0, 1'b0, 1'b0);
      chk_flags("b2b1", 1'b1, 1'b0);
      step(16'hF600, 32'd52, 1'b1, 1'b0, 1'b0);
      chk_flags("b2b2", 1'b0, 1'b1);
      expect_pkt(16'hF600, 16'h0002, 32'd53);
      step(16'h0002, 32'd53, 1'b0, 1'b0, 1'b0);
      chk_flags("b2b3", 1'b1, 1'b0);

      // drain: stall so nothing new is presented, then every expected packet must be consumed
      step(16'h0000, 32'd0, 1'b0, 1'b1, 1'b0);
      step(16'h0000, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("queue_empty", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
